// File: rtl/inst_hub_pkg.sv
// inst_hub_pkg: opcodes, FSM states and default widths shared by the exec hub files
package inst_hub_pkg;
   localparam int DEF_DW = 16;
   localparam int DEF_AW = 8;
   typedef enum logic [2:0] {
      OP_REG_WR  = 3'd0,
      OP_REG_RD  = 3'd1,
      OP_SUM_RD  = 3'd2,
      OP_FIFO_WR = 3'd3,
      OP_FIFO_RD = 3'd4,
      OP_RAM_WR  = 3'd5,
      OP_RAM_RD  = 3'd6,
      OP_RSVD    = 3'd7
   } op_e;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/inst_reg_bank.sv
// inst_reg_bank: output register bank with a live sum and a one-cycle-registered sum
module inst_reg_bank
   import inst_hub_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int NUM_REGS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [DW-1:0]          wdata,
   output logic [NUM_REGS*DW-1:0] regs,
   output logic [DW-1:0]          sum_now,
   output logic [DW-1:0]          sum_out
);
   logic [NUM_REGS*DW-1:0] regs_d, regs_q;
   logic [DW-1:0]          sum_d, sum_q;
   always_comb begin
      regs_d = regs_q;
      sum_d  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (we && 32'(waddr) == k) regs_d[k*DW +: DW] = wdata;
         sum_d = sum_d + regs_q[k*DW +: DW];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '0;
         sum_q  <= '0;
      end else begin
         regs_q <= regs_d;
         sum_q  <= sum_d;
      end
   end
   assign regs    = regs_q;
   assign sum_now = sum_d;
   assign sum_out = sum_q;
endmodule

// File: rtl/inst_exec_hub.sv
// inst_exec_hub: single-command executor for register, sum, FIFO and RAM operations
module inst_exec_hub
   import inst_hub_pkg::*;
#(
   parameter int DW         = DEF_DW,
   parameter int AW         = DEF_AW,
   parameter int NUM_REGS   = 3,
   parameter int RAM_RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_op,
   input  logic [AW-1:0]          cmd_addr,
   input  logic [DW-1:0]          cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DW-1:0]          rsp_data,
   output logic                   rsp_err,
   output logic [NUM_REGS*DW-1:0] reg_out,
   output logic [DW-1:0]          sum_out,
   output logic                   fifo_wreq,
   output logic [DW-1:0]          fifo_wdata,
   input  logic                   fifo_wfull,
   output logic                   fifo_rreq,
   input  logic [DW-1:0]          fifo_rdata,
   input  logic                   fifo_rempty,
   output logic                   ram_wreq,
   output logic [AW-1:0]          ram_waddr,
   output logic [DW-1:0]          ram_wdata,
   output logic [AW-1:0]          ram_raddr,
   input  logic [DW-1:0]          ram_rdata
);
   state_e        state_d, state_q;
   op_e           op_d, op_q;
   logic [AW-1:0] addr_d, addr_q;
   logic [DW-1:0] wdata_d, wdata_q;
   logic          wait_d, wait_q;
   logic          rsp_valid_d, rsp_valid_q;
   logic [DW-1:0] rsp_data_d, rsp_data_q;
   logic          rsp_err_d, rsp_err_q;
   logic          exec, reg_ok, reg_we;
   logic [DW-1:0] reg_rd, sum_now;
   // Strobes are gated by rst so nothing leaks out during an aborting reset cycle.
   assign exec      = state_q == S_EXEC && !rst;
   assign reg_ok    = 32'(addr_q) < NUM_REGS;
   assign reg_we    = exec && op_q == OP_REG_WR && reg_ok;
   assign cmd_ready = state_q == S_IDLE && en && !rst;
   assign fifo_wreq = exec && op_q == OP_FIFO_WR && !fifo_wfull;
   assign fifo_rreq = exec && op_q == OP_FIFO_RD && !fifo_rempty;
   assign ram_wreq  = exec && op_q == OP_RAM_WR;
   assign fifo_wdata = rst ? '0 : wdata_q;
   assign ram_wdata  = rst ? '0 : wdata_q;
   assign ram_waddr  = rst ? '0 : addr_q;
   assign ram_raddr  = rst ? '0 : addr_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   inst_reg_bank #(.DW(DW), .AW(AW), .NUM_REGS(NUM_REGS)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (reg_we),
      .waddr   (addr_q),
      .wdata   (wdata_q),
      .regs    (reg_out),
      .sum_now (sum_now),
      .sum_out (sum_out)
   );
   always_comb begin
      reg_rd = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (32'(addr_q) == k) reg_rd = reg_out[k*DW +: DW];
   end
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wait_d      = wait_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: if (cmd_valid && en) begin
            state_d = S_EXEC;
            op_d    = op_e'(cmd_op);
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
         end
         S_EXEC: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
            case (op_q)
               OP_REG_WR:  rsp_err_d = !reg_ok;
               OP_REG_RD:  begin
                  rsp_err_d  = !reg_ok;
                  rsp_data_d = reg_ok ? reg_rd : '0;
               end
               OP_SUM_RD:  rsp_data_d = sum_now;
               OP_FIFO_WR: rsp_err_d = fifo_wfull;
               OP_FIFO_RD: if (fifo_rempty) rsp_err_d = 1'b1;
                           else begin
                              state_d     = S_WAIT;
                              rsp_valid_d = 1'b0;
                              wait_d      = 1'b0;
                           end
               OP_RAM_WR:  rsp_err_d = 1'b0;
               OP_RAM_RD:  begin
                  state_d     = S_WAIT;
                  rsp_valid_d = 1'b0;
                  wait_d      = RAM_RD_LAT > 1;
               end
               default:    rsp_err_d = 1'b1;
            endcase
         end
         S_WAIT: if (wait_q) wait_d = 1'b0;
         else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = op_q == OP_FIFO_RD ? fifo_rdata : ram_rdata;
         end
         S_RESP: if (rsp_ready) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_REG_WR;
         addr_q      <= '0;
         wdata_q     <= '0;
         wait_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wait_q      <= wait_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end
endmodule
